// File: rtl/pi_compensator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_compensator_pkg
// Description : Shared constants and FSM state type for the PI compensator.
// Revision    : 1.0 - initial release
// ============================================================================
package pi_compensator_pkg;

    localparam int c_err_w = 13;
    localparam int c_prod_w = 22;
    localparam logic [c_err_w:0] c_zero_err = 14'd4096;

    localparam logic [c_err_w-1:0] c_ilim_default = 13'd3500;
    localparam logic [c_err_w-1:0] c_tlim_default = 13'd3800;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_INTEG = 3'd2,
        ST_OUT   = 3'd3,
        ST_FLT   = 3'd4
    } state_t;

endpackage : pi_compensator_pkg
`default_nettype wire

// File: rtl/pi_compensator_sat_clamp.sv
`default_nettype none
// ============================================================================
// Module      : pi_compensator_sat_clamp
// Description : Combinational signed saturation of IN_W bits into [LO, HI].
// Revision    : 1.0 - initial release
// ============================================================================
module pi_compensator_sat_clamp #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 24,
    parameter int LO    = 0,
    parameter int HI    = 57600
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic        [OUT_W-1:0] o_dout
);

    localparam logic signed [IN_W-1:0] c_lo = IN_W'(LO);
    localparam logic signed [IN_W-1:0] c_hi = IN_W'(HI);

    always_comb begin
        if (i_din < c_lo) begin
            o_dout = c_lo[OUT_W-1:0];
        end else if (i_din > c_hi) begin
            o_dout = c_hi[OUT_W-1:0];
        end else begin
            o_dout = i_din[OUT_W-1:0];
        end
    end

endmodule : pi_compensator_sat_clamp
`default_nettype wire

// File: rtl/pi_compensator.sv
`default_nettype none
// ============================================================================
// Module      : pi_compensator
// Description : PI compensator turning the Vout error into a clamped DPWM duty,
//               with anti-windup and sticky over-current/over-temp fault.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_compensator
    import pi_compensator_pkg::*;
#(
    parameter logic [7:0]         KP       = 8'd16,
    parameter logic [7:0]         KI       = 8'd1,
    parameter int                 FRAC     = 6,
    parameter int                 ACC_W    = 24,
    parameter int                 DUTY_W   = 10,
    parameter int                 DUTY_MAX = 900,
    parameter int                 DUTY_MIN = 0,
    parameter logic [c_err_w-1:0] ILIM     = c_ilim_default,
    parameter logic [c_err_w-1:0] TLIM     = c_tlim_default
) (
    input  logic               CLOCK_50,
    input  logic               RSTp,
    input  logic               SAMPLE_VALID,
    input  logic [c_err_w-1:0] Vout_err,
    input  logic [c_err_w-1:0] Iout,
    input  logic [c_err_w-1:0] Temp,
    output logic [DUTY_W-1:0]  DUTY,
    output logic               DUTY_VALID,
    output logic               FAULT,
    output logic               OVERRUN
);

    localparam int c_sum_w  = ACC_W + 1;
    localparam int c_acc_hi = DUTY_MAX * (2 ** FRAC);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [c_err_w:0]    r_e;
    logic signed [c_prod_w-1:0] r_p;
    logic signed [c_prod_w-1:0] r_i;
    logic signed [ACC_W-1:0]    r_acc;

    logic                       w_trip;
    logic                       w_busy;
    logic signed [c_err_w:0]    w_e;
    logic signed [c_prod_w-1:0] w_e_ext;
    logic signed [c_prod_w-1:0] w_kp;
    logic signed [c_prod_w-1:0] w_ki;
    logic signed [c_prod_w-1:0] w_p_nxt;
    logic signed [c_prod_w-1:0] w_i_nxt;
    logic signed [c_sum_w-1:0]  w_acc_sum;
    logic signed [c_sum_w-1:0]  w_out_sum;
    logic signed [c_sum_w-1:0]  w_out_shift;
    logic        [ACC_W-1:0]    w_acc_clamped;
    logic        [DUTY_W-1:0]   w_duty;

    assign w_trip = (Iout > ILIM) || (Temp > TLIM);
    assign w_busy = (r_state == ST_MULT) || (r_state == ST_INTEG) || (r_state == ST_OUT);
    assign w_e    = $signed({1'b0, Vout_err}) - $signed(c_zero_err);

    // Operands widened to the product width so the signed multiply cannot wrap.
    assign w_e_ext = {{(c_prod_w-c_err_w-1){r_e[c_err_w]}}, r_e};
    assign w_kp    = {{(c_prod_w-8){1'b0}}, KP};
    assign w_ki    = {{(c_prod_w-8){1'b0}}, KI};
    assign w_p_nxt = w_e_ext * w_kp;
    assign w_i_nxt = w_e_ext * w_ki;

    assign w_acc_sum   = {r_acc[ACC_W-1], r_acc} + {{(c_sum_w-c_prod_w){r_i[c_prod_w-1]}}, r_i};
    assign w_out_sum   = {r_acc[ACC_W-1], r_acc} + {{(c_sum_w-c_prod_w){r_p[c_prod_w-1]}}, r_p};
    assign w_out_shift = w_out_sum >>> FRAC;

    pi_compensator_sat_clamp #(
        .IN_W  (c_sum_w),
        .OUT_W (ACC_W),
        .LO    (0),
        .HI    (c_acc_hi)
    ) u_acc_clamp (
        .i_din  (w_acc_sum),
        .o_dout (w_acc_clamped)
    );

    pi_compensator_sat_clamp #(
        .IN_W  (c_sum_w),
        .OUT_W (DUTY_W),
        .LO    (DUTY_MIN),
        .HI    (DUTY_MAX)
    ) u_duty_clamp (
        .i_din  (w_out_shift),
        .o_dout (w_duty)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RSTp) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (SAMPLE_VALID) w_state_nxt = w_trip ? ST_FLT : ST_MULT;
            ST_MULT:  w_state_nxt = ST_INTEG;
            ST_INTEG: w_state_nxt = ST_OUT;
            ST_OUT:   w_state_nxt = ST_IDLE;
            ST_FLT:   w_state_nxt = ST_FLT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RSTp) begin
            r_e        <= '0;
            r_p        <= '0;
            r_i        <= '0;
            r_acc      <= '0;
            DUTY       <= '0;
            DUTY_VALID <= 1'b0;
            FAULT      <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            DUTY_VALID <= 1'b0;
            if (SAMPLE_VALID && w_busy) begin
                OVERRUN <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (SAMPLE_VALID) begin
                        if (w_trip) begin
                            DUTY  <= '0;
                            r_acc <= '0;
                            FAULT <= 1'b1;
                        end else begin
                            r_e <= w_e;
                        end
                    end
                end
                ST_MULT: begin
                    r_p <= w_p_nxt;
                    r_i <= w_i_nxt;
                end
                ST_INTEG: r_acc <= w_acc_clamped;
                ST_OUT: begin
                    DUTY       <= w_duty;
                    DUTY_VALID <= 1'b1;
                end
                ST_FLT:  DUTY <= '0;
                default: ;
            endcase
        end
    end

endmodule : pi_compensator
`default_nettype wire
